dmem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency data memory between the instruction-fetch stage (IF port) and the MEM stage (D port) of the pipelined core. Each access is sequenced through issue, wait and response phases. The arbiter drives per-port stall signals back into the pipeline registers and captures read data into per-port holding registers. Arbitration is fixed priority to the D port, with a starvation limit that guarantees forward progress for instruction fetch.

---
 rtl/dmem_port_arbiter_if.sv | 38 +++
 rtl/dmem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM pipeline ports, the arbiter and the
// single-port data memory.
interface dmem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        flush;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        stall_if;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_be;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        stall_mem;

    logic        m_en;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic [63:0] m_rdata;

    modport slave (
        input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
        output if_done, if_rdata, stall_if, d_done, d_rdata, stall_mem,
               m_en, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
        input  if_done, if_rdata, stall_if, d_done, d_rdata, stall_mem,
               m_en, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Fixed-priority (D over IF) arbiter for one fixed-latency single-port data
// memory, with an IF starvation limit and flush-based kill of IF accesses.
module dmem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [3:0]  starve_reg;
    logic        owner_reg;      // 1 = IF owns the access in flight
    logic        is_store_reg;
    logic        if_kill_reg;
    logic        m_en_reg, m_we_reg;
    logic [63:0] m_addr_reg, m_wdata_reg;
    logic [7:0]  m_be_reg;
    logic [63:0] if_rdata_reg, d_rdata_reg;

    logic        if_ok, both_req, grant_d, grant_if, last_wait, kill_now;
    logic        if_done_next, d_done_next;

    assign if_ok     = bus.if_req && !bus.flush;
    assign both_req  = if_ok && bus.d_req;
    assign grant_d   = (state_reg == IDLE) && bus.d_req && !(if_ok && starve_reg == STARVE_LIM);
    assign grant_if  = (state_reg == IDLE) && if_ok && !grant_d;
    assign last_wait = (state_reg == WAIT) && (cnt_reg == LAT_LAST);
    // A flush in the current cycle kills the IF result immediately, not just from the next cycle.
    assign kill_now  = owner_reg && (if_kill_reg || bus.flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (grant_d || grant_if) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == LAT_LAST) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if_done_next = 1'b0;
        d_done_next  = 1'b0;
        if (state_reg == RESP) begin
            if (owner_reg) begin
                if_done_next = !kill_now;
            end else begin
                d_done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            starve_reg   <= '0;
            owner_reg    <= 1'b0;
            is_store_reg <= 1'b0;
            if_kill_reg  <= 1'b0;
            m_en_reg     <= 1'b0;
            m_we_reg     <= 1'b0;
            m_addr_reg   <= '0;
            m_wdata_reg  <= '0;
            m_be_reg     <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            cnt_reg <= (state_reg == WAIT) ? cnt_reg + 4'd1 : 4'd0;

            if (grant_if) begin
                starve_reg <= '0;
            end else if (grant_d && both_req && starve_reg != STARVE_LIM) begin
                starve_reg <= starve_reg + 4'd1;
            end

            if (grant_d || grant_if) begin
                owner_reg    <= grant_if;
                is_store_reg <= grant_d && bus.d_we;
            end

            if (state_reg == IDLE || state_reg == RESP) begin
                if_kill_reg <= 1'b0;
            end else if (owner_reg && bus.flush) begin
                if_kill_reg <= 1'b1;
            end

            // The m_* registers only carry a request during ISSUE.
            if (grant_d) begin
                m_en_reg    <= 1'b1;
                m_we_reg    <= bus.d_we;
                m_addr_reg  <= bus.d_addr;
                m_wdata_reg <= bus.d_wdata;
                m_be_reg    <= bus.d_we ? bus.d_be : 8'hFF;
            end else if (grant_if) begin
                m_en_reg    <= 1'b1;
                m_we_reg    <= 1'b0;
                m_addr_reg  <= bus.if_addr;
                m_wdata_reg <= '0;
                m_be_reg    <= 8'hFF;
            end else begin
                m_en_reg    <= 1'b0;
                m_we_reg    <= 1'b0;
                m_addr_reg  <= '0;
                m_wdata_reg <= '0;
                m_be_reg    <= '0;
            end

            if (last_wait) begin
                if (owner_reg && !kill_now) begin
                    if_rdata_reg <= bus.m_rdata;
                end else if (!owner_reg && !is_store_reg) begin
                    d_rdata_reg <= bus.m_rdata;
                end
            end
        end
    end

    assign bus.if_done   = if_done_next;
    assign bus.d_done    = d_done_next;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.stall_if  = bus.if_req && !if_done_next && !bus.flush;
    assign bus.stall_mem = bus.d_req && !d_done_next;
    assign bus.m_en      = m_en_reg;
    assign bus.m_we      = m_we_reg;
    assign bus.m_addr    = m_addr_reg;
    assign bus.m_wdata   = m_wdata_reg;
    assign bus.m_be      = m_be_reg;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: main instance MEM_LAT=2/STARVE_MAX=2,
// second instance MEM_LAT=1 for the minimum-latency case.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus();
    dmem_port_arbiter_if bus1();

    dmem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    dmem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Memory model for the main instance: two-stage read pipe (MEM_LAT=2).
    logic [63:0] mem [0:31];
    logic [63:0] rd_p0, rd_p1, rd1;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            mem[8]  <= 64'hDEADBEEF_00000011;
            mem[16] <= 64'hCAFEF00D_00000080;
            mem[17] <= 64'h11112222_33334444;
        end else if (bus.m_en && bus.m_we) begin
            mem[bus.m_addr[7:3]] <= merge(mem[bus.m_addr[7:3]], bus.m_wdata, bus.m_be);
        end
        rd_p0 <= (bus.m_en && !bus.m_we) ? mem[bus.m_addr[7:3]] : 64'h0;
        rd_p1 <= rd_p0;
        rd1   <= bus1.m_en ? {bus1.m_addr[31:0], ~bus1.m_addr[31:0]} : 64'h0;
    end
    assign bus.m_rdata  = rd_p1;
    assign bus1.m_rdata = rd1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        is_if;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    function automatic void push(input logic is_if, input logic [63:0] data);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        sbq.push_back(e);
    endfunction

    // Monitor: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        if (bus.if_done || bus.d_done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got if_done=%b d_done=%b expected none", bus.if_done, bus.d_done);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_port_is_if", {63'd0, bus.if_done}, {63'd0, mon_e.is_if});
                chk("sb_port_is_d", {63'd0, bus.d_done}, {63'd0, !mon_e.is_if});
                chk("sb_rdata", mon_e.is_if ? bus.if_rdata : bus.d_rdata, mon_e.data);
                $display("done %s data=%h", mon_e.is_if ? "IF" : "D", mon_e.is_if ? bus.if_rdata : bus.d_rdata);
            end
        end
    end

    task automatic d_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] be);
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) chk("m_en_cycle0", {63'd0, bus.m_en}, 64'd0);
            if (k == 1) begin
                chk("m_en_issue", {63'd0, bus.m_en}, 64'd1);
                chk("m_we_issue", {63'd0, bus.m_we}, {63'd0, we});
                chk("m_be_issue", {56'd0, bus.m_be}, we ? {56'd0, be} : 64'hFF);
                chk("m_addr_issue", bus.m_addr, addr);
                if (we) chk("m_wdata_issue", bus.m_wdata, wdata);
            end
            if (k == 2) begin
                chk("m_en_wait", {63'd0, bus.m_en}, 64'd0);
                chk("stall_mem_wait", {63'd0, bus.stall_mem}, 64'd1);
            end
            if (bus.d_done) begin
                seen = 1;
                chk("d_done_cycle", 64'(k), 64'd4);
                chk("stall_mem_done", {63'd0, bus.stall_mem}, 64'd0);
            end
        end
        if (!seen) chk("d_done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic if_access(input logic [63:0] addr);
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = addr;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("if_m_we", {63'd0, bus.m_we}, 64'd0);
                chk("if_m_be", {56'd0, bus.m_be}, 64'hFF);
                chk("if_m_addr", bus.m_addr, addr);
            end
            if (bus.if_done) begin
                seen = 1;
                chk("if_done_cycle", 64'(k), 64'd4);
                chk("stall_if_done", {63'd0, bus.stall_if}, 64'd0);
            end
        end
        if (!seen) chk("if_done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn, first, second;
        bit seen, dropped;
        rst = 1'b1; mem_init = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.flush = 0;
        bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0; bus1.d_be = 0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("rst_m_en", {63'd0, bus.m_en}, 64'd0);
        chk("rst_m_addr", bus.m_addr, 64'd0);
        chk("rst_m_be", {56'd0, bus.m_be}, 64'd0);
        chk("rst_if_rdata", bus.if_rdata, 64'd0);
        chk("rst_d_rdata", bus.d_rdata, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_stall_if", {63'd0, bus.stall_if}, 64'd0);
        chk("idle_stall_mem", {63'd0, bus.stall_mem}, 64'd0);

        // Single load, then store, IF read, and load of the merged word
        push(0, 64'hDEADBEEF_00000011);
        d_access(0, 64'h40, 64'h0, 8'h00);
        push(0, 64'hDEADBEEF_00000011);
        d_access(1, 64'h40, 64'h1234, 8'h0F);
        push(1, 64'hCAFEF00D_00000080);
        if_access(64'h80);
        push(0, 64'hDEADBEEF_00001234);
        d_access(0, 64'h40, 64'h0, 8'h00);

        // Flush at cycle 2 of an IF read
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 64'h88;
        @(negedge clk); chk("flush_stall_if_c0", {63'd0, bus.stall_if}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("flush_m_en_c1", {63'd0, bus.m_en}, 64'd1);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(negedge clk); chk("flush_stall_if_c2", {63'd0, bus.stall_if}, 64'd0);
        @(posedge clk); #1 bus.flush = 1'b0; bus.if_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); chk("flush_no_done_c4", {63'd0, bus.if_done}, 64'd0);
        @(posedge clk); #1;
        push(0, 64'hDEADBEEF_00001234);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h40;
        @(posedge clk); #1;
        @(negedge clk); chk("flush_idle_at_c5", {63'd0, bus.m_en}, 64'd1);
        seen = 0;
        for (int k = 7; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.d_done) begin
                seen = 1;
                chk("flush_next_done_cycle", 64'(k), 64'd9);
            end
        end
        if (!seen) chk("flush_next_timeout", 64'd0, 64'd1);
        chk("flush_if_rdata_kept", bus.if_rdata, 64'hCAFEF00D_00000080);
        @(posedge clk); #1 bus.d_req = 1'b0;

        // Starvation: both held, expect D, D, IF, D, D, IF
        for (int r = 0; r < 2; r++) begin
            push(0, 64'hDEADBEEF_00001234);
            push(0, 64'hDEADBEEF_00001234);
            push(1, 64'hCAFEF00D_00000080);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_addr = 64'h40; bus.if_req = 1'b1; bus.if_addr = 64'h80;
        n = 0;
        for (int k = 0; k < 80 && n < 6; k++) begin
            @(negedge clk);
            if (bus.if_done || bus.d_done) n++;
        end
        chk("starve_done_count", 64'(n), 64'd6);
        @(posedge clk); #1 bus.d_req = 1'b0; bus.if_req = 1'b0;

        // Reset while in WAIT
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h40;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; bus.d_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_d_rdata", bus.d_rdata, 64'd0);
        chk("rstmid_if_rdata", bus.if_rdata, 64'd0);
        chk("rstmid_d_done", {63'd0, bus.d_done}, 64'd0);
        chk("rstmid_m_en", {63'd0, bus.m_en}, 64'd0);
        repeat (6) @(negedge clk);
        push(0, 64'hDEADBEEF_00001234);
        d_access(0, 64'h40, 64'h0, 8'h00);

        // Minimum latency, back-to-back loads on the MEM_LAT=1 instance
        @(posedge clk); #1;
        bus1.d_req = 1'b1; bus1.d_addr = 64'h100;
        dn = 0; first = -1; second = -1; dropped = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus1.d_done) begin
                if (dn == 0) first = k;
                else if (dn == 1) second = k;
                dn++;
                chk("minlat_rdata", bus1.d_rdata, 64'h00000100_FFFFFEFF);
                $display("done D(lat1) cycle=%0d data=%h", k, bus1.d_rdata);
            end
            if (dn == 2 && !dropped) begin
                dropped = 1;
                @(posedge clk); #1 bus1.d_req = 1'b0;
            end
        end
        chk("minlat_first", 64'(first), 64'd3);
        chk("minlat_second", 64'(second), 64'd7);
        chk("minlat_count", 64'(dn), 64'd2);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
